res_port_arbiter: RTL and testbench

//   Shares the single-port 128x128x8 result memory (res_rd/res_wr/res_addr/res_do/res_di) between two requesters:
//   A = distance-transform engine, B = host readback/debug port.

---
 rtl/res_port_arbiter.sv | 91 +++++++++
 tb/tb_res_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/res_port_arbiter.sv
// res_port_arbiter: round-robin arbiter with a time-bounded lock, sharing one result memory port
module res_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              res_rd,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di
);
  localparam int CNT_W = $clog2(MAX_LOCK);
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} own_t;
  own_t r_own, w_own_nxt;
  logic r_last_b;
  logic r_tag_b;
  logic [CNT_W-1:0] r_lock_cnt;
  logic w_a_none, w_xfer, w_we, w_lock, w_timeout;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  // with no owner, A wins alone or on a tie when B won last
  assign w_a_none  = a_req & (~b_req | r_last_b);
  assign a_gnt     = reset & a_req & (r_own == OWN_A | (r_own == OWN_NONE & w_a_none));
  assign b_gnt     = reset & b_req & (r_own == OWN_B | (r_own == OWN_NONE & ~w_a_none));
  assign w_xfer    = a_gnt | b_gnt;
  assign w_we      = b_gnt ? b_we : a_we;
  assign w_lock    = b_gnt ? b_lock : a_lock;
  assign w_addr    = b_gnt ? b_addr : a_addr;
  assign w_wdata   = b_gnt ? b_wdata : a_wdata;
  assign w_timeout = (r_own != OWN_NONE) & (r_lock_cnt == CNT_W'(MAX_LOCK - 1));
  always_comb begin
    w_own_nxt = r_own;
    if (r_own == OWN_NONE)
      w_own_nxt = (w_xfer & w_lock) ? (b_gnt ? OWN_B : OWN_A) : OWN_NONE;
    else if (w_timeout | (w_xfer & ~w_lock))
      w_own_nxt = OWN_NONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_own      <= OWN_NONE;
      r_last_b   <= 1'b1;
      r_tag_b    <= 1'b0;
      r_lock_cnt <= '0;
      res_rd     <= 1'b0;
      res_wr     <= 1'b0;
      res_addr   <= '0;
      res_do     <= '0;
      a_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rvalid   <= 1'b0;
      b_rdata    <= '0;
    end else begin
      r_own      <= w_own_nxt;
      r_lock_cnt <= (r_own == OWN_NONE) ? '0 : r_lock_cnt + 1'b1;
      res_rd     <= w_xfer & ~w_we;
      res_wr     <= w_xfer & w_we;
      if (w_xfer) begin
        res_addr <= w_addr;
        res_do   <= w_wdata;
        r_last_b <= b_gnt;
        r_tag_b  <= b_gnt;
      end else if (w_timeout) begin
        r_last_b <= (r_own == OWN_B);
      end
      // memory data is valid during the res_rd cycle; return it to whoever issued it
      a_rvalid <= res_rd & ~r_tag_b;
      b_rvalid <= res_rd & r_tag_b;
      if (res_rd & ~r_tag_b) a_rdata <= res_di;
      if (res_rd & r_tag_b) b_rdata <= res_di;
    end
  end
endmodule

// File: tb/tb_res_port_arbiter.sv
// tb_res_port_arbiter: directed scenarios plus randomized traffic checked against a behavioural model
module tb_res_port_arbiter;
  localparam int AW = 14, DW = 8, MAX_LOCK = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic a_req = 0, a_we = 0, a_lock = 0, b_req = 0, b_we = 0, b_lock = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_gnt, a_rvalid, b_gnt, b_rvalid, res_rd, res_wr;
  logic [DW-1:0] a_rdata, b_rdata, res_do, res_di;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int checks = 0, errors = 0;

  res_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .res_di(res_di));

  always #5 clk = ~clk;
  assign res_di = mem[res_addr];
  always @(posedge clk) if (res_wr) mem[res_addr] <= res_do;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: owner 0=none 1=A 2=B; reads return shadow data two steps after acceptance
  typedef struct {int due; bit who; logic [DW-1:0] d;} ret_t;
  ret_t q[$];
  int owner = 0, cnt = 0, step_n = 0;
  bit last_b = 1, m_ga = 0, m_gb = 0;
  logic e_rd = 0, e_wr = 0, e_rva = 0, e_rvb = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_do = '0, e_rda = '0, e_rdb = '0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_ctl", {a_gnt, b_gnt, a_rvalid, b_rvalid, res_rd, res_wr}, 0);
      chk("rst_data", {a_rdata, b_rdata, res_addr, res_do}, 0);
      owner = 0; cnt = 0; last_b = 1; m_ga = 0; m_gb = 0; q.delete();
      e_rd = 0; e_wr = 0; e_rva = 0; e_rvb = 0; e_addr = '0; e_do = '0; e_rda = '0; e_rdb = '0;
    end else begin
      bit ga, gb, tr, we, lk;
      ga = owner == 1 ? a_req : owner == 2 ? 1'b0 : a_req && (!b_req || last_b);
      gb = owner == 2 ? b_req : owner == 1 ? 1'b0 : b_req && !(a_req && last_b);
      chk("a_gnt", a_gnt, ga);
      chk("b_gnt", b_gnt, gb);
      chk("one_gnt", a_gnt & b_gnt, 0);
      chk("res_rd", res_rd, e_rd);
      chk("res_wr", res_wr, e_wr);
      chk("res_addr", res_addr, e_addr);
      chk("res_do", res_do, e_do);
      chk("a_rvalid", a_rvalid, e_rva);
      chk("a_rdata", a_rdata, e_rda);
      chk("b_rvalid", b_rvalid, e_rvb);
      chk("b_rdata", b_rdata, e_rdb);
      m_ga = ga; m_gb = gb;
      tr = ga || gb; we = gb ? b_we : a_we; lk = gb ? b_lock : a_lock;
      step_n++;
      e_rd = tr && !we; e_wr = tr && we;
      if (tr) begin
        e_addr = gb ? b_addr : a_addr;
        e_do = gb ? b_wdata : a_wdata;
        last_b = gb;
        if (we) shadow[e_addr] = e_do;
        else q.push_back('{step_n + 1, gb, shadow[e_addr]});
      end
      e_rva = 0; e_rvb = 0;
      if (q.size() > 0 && q[0].due == step_n) begin
        if (q[0].who) begin e_rvb = 1; e_rdb = q[0].d; end
        else begin e_rva = 1; e_rda = q[0].d; end
        void'(q.pop_front());
      end
      if (owner == 0) begin
        if (tr && lk) begin owner = gb ? 2 : 1; cnt = 0; end
      end else if (cnt == MAX_LOCK - 1) begin
        last_b = owner == 2; owner = 0;
      end else if (tr && !lk) owner = 0;
      else cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rnd_drive(input int lock_pct);
    if (!(a_req && !m_ga)) begin
      a_req = $urandom_range(0, 99) < 60; a_we = 1'($urandom); a_lock = $urandom_range(0, 99) < lock_pct;
      a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
    end
    if (!(b_req && !m_gb)) begin
      b_req = $urandom_range(0, 99) < 60; b_we = 1'($urandom); b_lock = $urandom_range(0, 99) < lock_pct;
      b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = DW'($urandom);
      shadow[i] = mem[i];
    end
    mem[129] = 8'd5; shadow[129] = 8'd5;
    repeat (2) step();
    reset = 1;
    step();
    // single A read returns memory contents two edges after acceptance
    a_req = 1; a_we = 0; a_lock = 0; a_addr = 129;
    @(negedge clk); chk("t1_gnt", {a_gnt, b_gnt}, 2'b10);
    step(); a_req = 0;
    @(negedge clk); chk("t1_rd", {res_rd, res_wr, res_addr}, {2'b10, 14'd129});
    step();
    @(negedge clk); chk("t1_ret", {a_rvalid, a_rdata, b_rvalid}, {1'b1, 8'd5, 1'b0});
    step();
    // contention alternates; A won last so B goes first
    a_req = 1; a_addr = 1000; b_req = 1; b_we = 0; b_lock = 0; b_addr = 2000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_gnt", {a_gnt, b_gnt}, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) chk("t2_addr", res_addr, (i % 2) ? 14'd2000 : 14'd1000);
      step();
    end
    a_req = 0; b_req = 0;
    step();
    // A locks for a read-modify-write; B is held off until the unlocking write
    a_req = 1; a_we = 0; a_lock = 1; a_addr = 200;
    @(negedge clk); chk("t3_lock", a_gnt, 1);
    step(); a_req = 0; b_req = 1; b_addr = 201;
    @(negedge clk); chk("t3_hold1", b_gnt, 0);
    step();
    @(negedge clk); chk("t3_hold2", b_gnt, 0);
    step(); a_req = 1; a_we = 1; a_lock = 0; a_wdata = 7;
    @(negedge clk); chk("t3_wr", {a_gnt, b_gnt}, 2'b10);
    step(); a_req = 0;
    @(negedge clk); chk("t3_b", b_gnt, 1);
    step(); b_req = 0;
    step();
    // lock held past the timeout is released after MAX_LOCK owned cycles
    a_req = 1; a_we = 0; a_lock = 1; a_addr = 10;
    @(negedge clk); chk("t4_enter", a_gnt, 1);
    step(); b_req = 1; b_addr = 11;
    for (int i = 1; i <= MAX_LOCK; i++) begin
      @(negedge clk); chk("t4_owned", {a_gnt, b_gnt}, 2'b10);
      step();
    end
    @(negedge clk); chk("t4_release", {a_gnt, b_gnt}, 2'b01);
    step(); a_req = 0; b_req = 0; a_lock = 0;
    step();
    // write then read of the same address from the other port sees the new data
    a_req = 1; a_we = 1; a_addr = 300; a_wdata = 9;
    @(negedge clk); chk("t5_wgnt", a_gnt, 1);
    step(); a_req = 0; b_req = 1; b_we = 0; b_addr = 300;
    @(negedge clk); chk("t5_rgnt", b_gnt, 1);
    step(); b_req = 0;
    step();
    @(negedge clk); chk("t5_ret", {b_rvalid, b_rdata}, {1'b1, 8'd9});
    step();
    // reset during the memory read cycle drops the return
    b_req = 1; b_addr = 50;
    @(negedge clk); chk("t6_gnt", b_gnt, 1);
    step(); b_req = 0; reset = 0;
    @(negedge clk); chk("t6_rst", {res_rd, b_rvalid}, 0);
    step(); reset = 1;
    @(negedge clk); chk("t6_norv", b_rvalid, 0);
    step(); a_req = 1; a_we = 0; a_addr = 60; b_req = 1; b_addr = 61;
    @(negedge clk); chk("t6_tie", {a_gnt, b_gnt}, 2'b10);
    step(); a_req = 0;
    step(); b_req = 0;
    step();
    // randomized traffic with alternating lock intensity and occasional resets
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 500; i++) begin
        step();
        reset = !(!m_ga && !m_gb && $urandom_range(0, 299) == 0);
        rnd_drive((s % 2) ? 92 : 15);
      end
    end
    step(); reset = 1; a_req = 0; b_req = 0;
    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
